// File: rtl/bsg_fifo_1r1w_rf.sv
// Ready/valid FIFO controller for an external 1R1W async-read register file; holds only pointers and count.
// Optional same-cycle empty bypass enabled by defining BSG_FIFO_1R1W_RF_BYPASS_EN.
`ifndef BSG_SAFE_CLOG2
`define BSG_SAFE_CLOG2(x) (((x) <= 1) ? 1 : $clog2(x))
`endif

module bsg_fifo_1r1w_rf #(
    parameter int width_p        = 8,
    parameter int els_p          = 4,
    parameter int addr_width_lp  = `BSG_SAFE_CLOG2(els_p),
    parameter int count_width_lp = `BSG_SAFE_CLOG2(els_p+1)
) (
    input  logic                      clk_i,
    input  logic                      reset_n_i,
    input  logic                      v_i,
    input  logic [width_p-1:0]        data_i,
    output logic                      ready_o,
    output logic                      v_o,
    output logic [width_p-1:0]        data_o,
    input  logic                      yumi_i,
    output logic [count_width_lp-1:0] count_o,
    output logic                      mem_w_v_o,
    output logic [addr_width_lp-1:0]  mem_w_addr_o,
    output logic [width_p-1:0]        mem_w_data_o,
    output logic                      mem_r_v_o,
    output logic [addr_width_lp-1:0]  mem_r_addr_o,
    input  logic [width_p-1:0]        mem_r_data_i
);

    localparam logic [count_width_lp-1:0] full_count_lp = count_width_lp'(els_p);
    localparam logic [addr_width_lp-1:0]  last_addr_lp  = addr_width_lp'(els_p - 1);

    logic [addr_width_lp-1:0]  wptr, rptr;
    logic [count_width_lp-1:0] count;
    logic                      not_empty;
    logic                      enq;
    logic                      mem_enq;
    logic                      mem_deq;

    // Explicit wrap so non-power-of-two depths never index past els_p-1.
    function automatic logic [addr_width_lp-1:0] next_ptr(input logic [addr_width_lp-1:0] p);
        return (p == last_addr_lp) ? '0 : p + addr_width_lp'(1);
    endfunction

    assign not_empty = (count != '0);
    assign ready_o   = (count != full_count_lp) & reset_n_i;
    assign enq       = v_i & ready_o;

`ifdef BSG_FIFO_1R1W_RF_BYPASS_EN
    logic bypass;
    // Empty FIFO forwards the incoming item; if consumed the same cycle it never touches memory.
    assign bypass  = ~not_empty & v_i & reset_n_i;
    assign v_o     = not_empty | bypass;
    assign data_o  = bypass ? data_i : mem_r_data_i;
    assign mem_enq = enq & ~(bypass & yumi_i);
`else
    assign v_o     = not_empty;
    assign data_o  = mem_r_data_i;
    assign mem_enq = enq;
`endif

    // Reads are gated by occupancy, so an illegal yumi on empty cannot underflow.
    assign mem_deq = yumi_i & not_empty;

    assign count_o      = count;
    assign mem_w_v_o    = mem_enq;
    assign mem_w_addr_o = wptr;
    assign mem_w_data_o = data_i;
    assign mem_r_v_o    = not_empty;
    assign mem_r_addr_o = rptr;

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else begin
            if (mem_enq) wptr <= next_ptr(wptr);
            if (mem_deq) rptr <= next_ptr(rptr);
            case ({mem_enq, mem_deq})
                2'b10:   count <= count + count_width_lp'(1);
                2'b01:   count <= count - count_width_lp'(1);
                default: count <= count;
            endcase
        end
    end

`ifndef SYNTHESIS
    yumi_needs_valid: assert property (@(posedge clk_i) disable iff (!reset_n_i) yumi_i |-> v_o)
        else $error("bsg_fifo_1r1w_rf: yumi_i asserted while v_o is low");
`endif

endmodule
